nyq_decim: RTL and testbench

Parametrised polyphase Nyquist decimator: low-pass FIR of DECIM*NUM_SEG taps with decimation by DECIM, computed with NUM_SEG time-shared MACs in transposed form. It is the next generation of the fixed 4-MAC / decimate-by-8 Nyquist block. New in this generation:
- input valid handshake instead of free-running sampling;
- run/clear control register;
- explicit fixed-point scaling and optional saturation.

It sits between the upstream sample source and the downstream rate-reduced chain, and is configured through the standard parameter-memory write port.

---
 rtl/nyq_decim_if.sv | 32 +++
 rtl/nyq_decim.sv | 129 ++++++++++++
 tb/tb_nyq_decim.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nyq_decim_if.sv
// nyq_decim_if: bundles the parameter-write port, the sample input stream and
// the decimated output of nyq_decim.
//   master : sample source / configuration side (drives writes and samples)
//   slave  : the decimator (consumes writes and samples, drives the output)
// Signals:
//   WrEn_SI, Addr_DI, PAR_In_DI : parameter memory write port
//   NYQ_In_DI, NYQ_InValid_SI   : signed input sample and its valid
//   NYQ_Out_DO, NYQ_Valid_DO    : signed decimated output and its update pulse
interface nyq_decim_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_WIDTH  = 24,
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned OUT_WIDTH  = 24
) ();
  logic                  WrEn_SI;
  logic [ADDR_WIDTH-1:0] Addr_DI;
  logic [MEM_WIDTH-1:0]  PAR_In_DI;
  logic [IN_WIDTH-1:0]   NYQ_In_DI;
  logic                  NYQ_InValid_SI;
  logic [OUT_WIDTH-1:0]  NYQ_Out_DO;
  logic                  NYQ_Valid_DO;

  modport master (
    output WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
    input  NYQ_Out_DO, NYQ_Valid_DO
  );

  modport slave (
    input  WrEn_SI, Addr_DI, PAR_In_DI, NYQ_In_DI, NYQ_InValid_SI,
    output NYQ_Out_DO, NYQ_Valid_DO
  );
endinterface

// File: rtl/nyq_decim.sv
// nyq_decim: polyphase Nyquist decimator. Low-pass FIR of DECIM*NUM_SEG taps,
// decimation by DECIM, computed with NUM_SEG time-shared MACs in transposed form.
// Ports:
//   Clk_CI : clock
//   Rst_RI : synchronous active-high reset
//   bus    : nyq_decim_if slave (parameter writes, sample stream, output)
// Coefficient h[k] lives at address k; address 2^ADDR_WIDTH-1 is the control
// word, bit 0 = Run.
// Build option: define NYQ_SAT_EN to saturate the shifted accumulator to
// OUT_WIDTH; otherwise the low OUT_WIDTH bits are taken (wrap).
// NUM_SEG must be at least 2.
module nyq_decim #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned MEM_WIDTH  = 24,
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned COEF_WIDTH = 24,
  parameter int unsigned DECIM      = 8,
  parameter int unsigned NUM_SEG    = 4,
  parameter int unsigned FRAC_BITS  = 23,
  parameter int unsigned ACC_WIDTH  = 53
) (
  input logic         Clk_CI,
  input logic         Rst_RI,
  nyq_decim_if.slave  bus
);
  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned PhW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADDR_WIDTH-1:0] CtrlAddr = ADDR_WIDTH'(Depth - 1);
  localparam logic [PhW-1:0]        LastPh   = PhW'(DECIM - 1);

  logic [MEM_WIDTH-1:0]        mem_q [Depth];
  logic [PhW-1:0]              phase_q;
  logic signed [ACC_WIDTH-1:0] acc_q [NUM_SEG];
  // rsum_q[i] holds R_(i+1); the last entry is R_NUM_SEG and stays zero.
  logic signed [ACC_WIDTH-1:0] rsum_q [NUM_SEG];
  logic [OUT_WIDTH-1:0]        out_q;
  logic                        valid_q;

  logic                        run;
  logic                        ctrl_stop;
  logic                        accept;
  logic [ADDR_WIDTH-1:0]       cidx [NUM_SEG];
  logic signed [ACC_WIDTH-1:0] coef_ext [NUM_SEG];
  logic signed [ACC_WIDTH-1:0] sum [NUM_SEG];
  logic signed [ACC_WIDTH-1:0] rsum_d [NUM_SEG];
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] y;
  logic signed [ACC_WIDTH-1:0] sh;
  logic [OUT_WIDTH-1:0]        out_d;

  assign run = mem_q[Depth-1][0];

  always_comb begin
    // A control write clearing Run drops the sample presented in the same cycle.
    ctrl_stop = bus.WrEn_SI && (bus.Addr_DI == CtrlAddr) && !bus.PAR_In_DI[0];
    accept    = bus.NYQ_InValid_SI && run && !ctrl_stop;
    x_ext     = ACC_WIDTH'($signed(bus.NYQ_In_DI));
    for (int unsigned j = 0; j < NUM_SEG; j++) begin
      // Segment j uses tap j*DECIM + (DECIM-1-p); memory is read before any
      // same-cycle write lands, so the old coefficient is used.
      cidx[j]     = ADDR_WIDTH'(j * DECIM + DECIM - 1) - ADDR_WIDTH'(phase_q);
      coef_ext[j] = ACC_WIDTH'($signed(mem_q[cidx[j]][COEF_WIDTH-1:0]));
      sum[j]      = acc_q[j] + x_ext * coef_ext[j];
    end
    for (int unsigned i = 0; i < NUM_SEG - 1; i++) begin
      rsum_d[i] = sum[i+1] + rsum_q[i+1];
    end
    rsum_d[NUM_SEG-1] = '0;
    y  = sum[0] + rsum_q[0];
    sh = y >>> FRAC_BITS;
`ifdef NYQ_SAT_EN
    if ((&sh[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|sh[ACC_WIDTH-1:OUT_WIDTH-1])) begin
      out_d = sh[OUT_WIDTH-1:0];
    end else if (sh[ACC_WIDTH-1]) begin
      out_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      out_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
`else
    out_d = sh[OUT_WIDTH-1:0];
`endif
  end

`ifndef NYQ_SAT_EN
  logic unused_sh_hi;
  assign unused_sh_hi = ^sh[ACC_WIDTH-1:OUT_WIDTH];
`endif

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      for (int unsigned i = 0; i < Depth; i++) mem_q[i] <= '0;
      for (int unsigned j = 0; j < NUM_SEG; j++) begin
        acc_q[j]  <= '0;
        rsum_q[j] <= '0;
      end
      phase_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (bus.WrEn_SI) mem_q[bus.Addr_DI] <= bus.PAR_In_DI;
      valid_q <= 1'b0;
      if (!run) begin
        // Stopped: flush history so a restart begins at phase 0, empty.
        phase_q <= '0;
        for (int unsigned j = 0; j < NUM_SEG; j++) begin
          acc_q[j]  <= '0;
          rsum_q[j] <= '0;
        end
      end else if (accept) begin
        if (phase_q == LastPh) begin
          phase_q <= '0;
          for (int unsigned j = 0; j < NUM_SEG; j++) begin
            acc_q[j]  <= '0;
            rsum_q[j] <= rsum_d[j];
          end
          out_q   <= out_d;
          valid_q <= 1'b1;
        end else begin
          phase_q <= phase_q + 1'b1;
          for (int unsigned j = 0; j < NUM_SEG; j++) acc_q[j] <= sum[j];
        end
      end
    end
  end

  assign bus.NYQ_Out_DO   = out_q;
  assign bus.NYQ_Valid_DO = valid_q;
endmodule

// File: tb/tb_nyq_decim.sv
// tb_nyq_decim: directed bench for nyq_decim. dut0 runs with FRAC_BITS=0 for the
// integer-valued cases, dut1 with default parameters for the overflow case.
// Both see identical stimulus.
module tb_nyq_decim;
  localparam logic [5:0] Ctrl = 6'd63;
`ifdef NYQ_SAT_EN
  localparam logic [31:0] OvfFirst = 32'h7FFFFF;
  localparam logic [31:0] OvfLast  = 32'h7FFFFF;
`else
  // 8*(2^23-1)^2 >>> 23 = 2^26-16 ; 32*(2^23-1)^2 >>> 23 = 2^28-64
  localparam logic [31:0] OvfFirst = 32'hFFFFF0;
  localparam logic [31:0] OvfLast  = 32'hFFFFC0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  int   vcnt  = 0;
  int   last_v;
  int   imp_exp [5] = '{8, 16, 24, 32, 0};
  int   dc_exp  [5] = '{800, 1600, 2400, 3200, 3200};

  nyq_decim_if if0 ();
  nyq_decim_if if1 ();

  nyq_decim #(.FRAC_BITS(0)) dut0 (.Clk_CI(clk), .Rst_RI(rst), .bus(if0));
  nyq_decim dut1 (.Clk_CI(clk), .Rst_RI(rst), .bus(if1));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (if0.NYQ_Valid_DO) vcnt <= vcnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [5:0] a, input logic [23:0] d,
                       input logic [23:0] x, input logic v);
    if0.WrEn_SI = we; if0.Addr_DI = a; if0.PAR_In_DI = d;
    if0.NYQ_In_DI = x; if0.NYQ_InValid_SI = v;
    if1.WrEn_SI = we; if1.Addr_DI = a; if1.PAR_In_DI = d;
    if1.NYQ_In_DI = x; if1.NYQ_InValid_SI = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [23:0] d);
    drive(1'b1, a, d, 24'd0, 1'b0);
    tick();
    drive(1'b0, 6'd0, 24'd0, 24'd0, 1'b0);
  endtask

  task automatic smp(input logic [23:0] x);
    drive(1'b0, 6'd0, 24'd0, x, 1'b1);
    tick();
    drive(1'b0, 6'd0, 24'd0, 24'd0, 1'b0);
  endtask

  task automatic fill(input logic [23:0] h);
    for (int k = 0; k < 32; k++) wr(6'(k), h);
  endtask

  // Run n samples of constant x and check valid/value at every sample.
  task automatic dc_run(input string tag, input int n, input logic [23:0] x);
    for (int i = 0; i < n; i++) begin
      smp(x);
      chk({tag, "_valid"}, 32'(if0.NYQ_Valid_DO), 32'((i % 8) == 7));
      if ((i % 8) == 7) chk({tag, "_out"}, 32'(if0.NYQ_Out_DO), 32'(dc_exp[i / 8]));
    end
  endtask

  initial begin
    // Reset with random activity on every input.
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'($urandom_range(1)), 6'($urandom), 24'($urandom), 24'($urandom),
            1'($urandom_range(1)));
      tick();
    end
    chk("rst_out0", 32'(if0.NYQ_Out_DO), 32'd0);
    chk("rst_valid0", 32'(if0.NYQ_Valid_DO), 32'd0);
    chk("rst_out1", 32'(if1.NYQ_Out_DO), 32'd0);
    drive(1'b0, 6'd0, 24'd0, 24'd0, 1'b0);
    tick();
    rst = 1'b0;

    // Run=0 after reset: samples are ignored.
    for (int i = 0; i < 16; i++) smp(24'd5);
    chk("run0_no_valid", 32'(vcnt), 32'd0);

    // Coefficients read back as zero through the datapath.
    wr(Ctrl, 24'd1);
    for (int i = 0; i < 8; i++) smp(24'd1000);
    chk("mem_zero_valid", 32'(if0.NYQ_Valid_DO), 32'd1);
    chk("mem_zero_out", 32'(if0.NYQ_Out_DO), 32'd0);
    wr(Ctrl, 24'd0);

    // Impulse response, h[k]=k+1.
    for (int k = 0; k < 32; k++) wr(6'(k), 24'(k + 1));
    wr(Ctrl, 24'd1);
    for (int i = 0; i < 40; i++) begin
      smp((i == 0) ? 24'd1 : 24'd0);
      chk("imp_valid", 32'(if0.NYQ_Valid_DO), 32'((i % 8) == 7));
      if ((i % 8) == 7) chk("imp_out", 32'(if0.NYQ_Out_DO), 32'(imp_exp[i / 8]));
    end

    // DC response, h=1, x=100.
    wr(Ctrl, 24'd0);
    fill(24'd1);
    wr(Ctrl, 24'd1);
    dc_run("dc", 40, 24'd100);

    // Same DC stimulus with valid every third cycle.
    wr(Ctrl, 24'd0);
    wr(Ctrl, 24'd1);
    last_v = -1;
    for (int i = 0; i < 40; i++) begin
      smp(24'd100);
      chk("gap_valid", 32'(if0.NYQ_Valid_DO), 32'((i % 8) == 7));
      if ((i % 8) == 7) begin
        chk("gap_out", 32'(if0.NYQ_Out_DO), 32'(dc_exp[i / 8]));
        if (last_v >= 0) chk("gap_spacing", 32'(cyc_n - last_v), 32'd24);
        last_v = cyc_n;
      end
      tick();
      chk("gap_pulse_len", 32'(if0.NYQ_Valid_DO), 32'd0);
      tick();
    end

    // Overflow on the default-scaled instance.
    wr(Ctrl, 24'd0);
    fill(24'h7FFFFF);
    wr(Ctrl, 24'd1);
    for (int i = 0; i < 32; i++) begin
      smp(24'h7FFFFF);
      if (i == 7) chk("ovf_first", 32'(if1.NYQ_Out_DO), OvfFirst);
    end
    chk("ovf_valid", 32'(if1.NYQ_Valid_DO), 32'd1);
    chk("ovf_last", 32'(if1.NYQ_Out_DO), OvfLast);

    // Mid-frame stop, restart, and same-cycle coefficient write.
    wr(Ctrl, 24'd0);
    fill(24'd1);
    wr(Ctrl, 24'd1);
    for (int i = 0; i < 5; i++) smp(24'd100);
    wr(Ctrl, 24'd0);
    wr(Ctrl, 24'd1);
    // h[7] is the tap used by segment 0 at phase 0; the write lands with that sample.
    drive(1'b1, 6'd7, 24'd5, 24'd100, 1'b1);
    tick();
    drive(1'b0, 6'd0, 24'd0, 24'd0, 1'b0);
    chk("mid_valid", 32'(if0.NYQ_Valid_DO), 32'd0);
    for (int i = 1; i < 16; i++) begin
      smp(24'd100);
      chk("mid_valid", 32'(if0.NYQ_Valid_DO), 32'((i % 8) == 7));
      // Frame 0 used the old h[7]=1; frame 1 sees h[7]=5: 100*(15+5).
      if (i == 7) chk("mid_first", 32'(if0.NYQ_Out_DO), 32'd800);
      if (i == 15) chk("mid_new_coef", 32'(if0.NYQ_Out_DO), 32'd2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
